lmsm_sequencer: RTL

- Sits between the decode pipeline register (pr2) and the register-read stage.
- Expands each LM/SM instruction into a series of single-register LW/SW micro-ops, one micro-op per set bit of imm8. The existing datapath, forwarding and pc-select logic then handle each transfer as an ordinary load or store.
- All other instructions pass through with one registered cycle of latency.
- Stalls fetch/decode while a multi-register expansion is in progress.

---
 rtl/lmsm_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/lmsm_sequencer.sv
// Expands LM/SM instructions into one LW/SW micro-op per selected register,
// lowest register first; everything else passes through with one cycle of latency.
module lmsm_sequencer #(
    parameter logic [3:0] LM_OP = 4'b0110,
    parameter logic [3:0] SM_OP = 4'b0111,
    parameter logic [3:0] LW_OP = 4'b0100,
    parameter logic [3:0] SW_OP = 4'b0101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ir_in,
    input  logic        ir_valid,
    input  logic        stall_in,
    input  logic        flush,
    output logic [15:0] uop_ir,
    output logic        uop_valid,
    output logic        fetch_stall,
    output logic        busy,
    output logic [0:0]  dbg_state_o
);

    // Handshake: uop_valid qualifies uop_ir. stall_in freezes every register,
    // and fetch_stall tells upstream to hold pr2 until the last micro-op is issued.
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEQ  = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    logic [2:0]  off_q, off_d;
    logic        base_load_q, base_load_d;
    logic [2:0]  base_ra_q, base_ra_d;
    logic [15:0] uop_q, uop_d;
    logic        vld_q, vld_d;

    logic        idle;
    logic        is_lmsm;
    logic        is_load;
    logic [2:0]  ra;
    logic [2:0]  cur_off;
    logic [7:0]  cur_list;
    logic [7:0]  rest;
    logic        multi;
    logic [2:0]  idx;
    logic [15:0] seq_uop;
    logic        unused_ir_bit;

    assign idle     = (state_q == S_IDLE);
    assign is_lmsm  = ir_valid && ((ir_in[15:12] == LM_OP) || (ir_in[15:12] == SM_OP));
    assign is_load  = idle ? (ir_in[15:12] == LM_OP) : base_load_q;
    assign ra       = idle ? ir_in[11:9] : base_ra_q;
    assign cur_off  = idle ? 3'd0 : off_q;
    assign cur_list = idle ? ir_in[7:0] : rem_q;
    // Clearing the lowest set bit leaves a non-zero word iff two or more bits were set.
    assign rest     = cur_list & (cur_list - 8'd1);
    assign multi    = (rest != 8'd0);
    assign unused_ir_bit = ir_in[8];

    always_comb begin
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cur_list[i]) idx = i[2:0];
        end
    end

    assign seq_uop = {(is_load ? LW_OP : SW_OP), idx, ra, 3'b000, cur_off};

    // Reset is folded in so the stall drops asynchronously along with the state.
    assign fetch_stall = reset && !flush && ((idle && is_lmsm && multi) || (!idle && multi));

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        off_d       = off_q;
        base_load_d = base_load_q;
        base_ra_d   = base_ra_q;
        uop_d       = uop_q;
        vld_d       = vld_q;
        if (flush) begin
            state_d = S_IDLE;
            rem_d   = 8'd0;
            off_d   = 3'd0;
            vld_d   = 1'b0;
        end else if (stall_in) begin
            vld_d = vld_q;
        end else if (idle) begin
            if (!ir_valid) begin
                vld_d = 1'b0;
            end else if (!is_lmsm) begin
                uop_d = ir_in;
                vld_d = 1'b1;
            end else if (cur_list == 8'd0) begin
                vld_d = 1'b0;
            end else begin
                uop_d = seq_uop;
                vld_d = 1'b1;
                if (multi) begin
                    state_d     = S_SEQ;
                    rem_d       = rest;
                    off_d       = 3'd1;
                    base_load_d = (ir_in[15:12] == LM_OP);
                    base_ra_d   = ir_in[11:9];
                end
            end
        end else begin
            if (rem_q == 8'd0) begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end else begin
                uop_d = seq_uop;
                vld_d = 1'b1;
                rem_d = rest;
                if (multi) begin
                    off_d = off_q + 3'd1;
                end else begin
                    state_d = S_IDLE;
                    off_d   = 3'd0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            rem_q       <= 8'd0;
            off_q       <= 3'd0;
            base_load_q <= 1'b0;
            base_ra_q   <= 3'd0;
            uop_q       <= 16'h0000;
            vld_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            off_q       <= off_d;
            base_load_q <= base_load_d;
            base_ra_q   <= base_ra_d;
            uop_q       <= uop_d;
            vld_q       <= vld_d;
        end
    end

    assign uop_ir      = uop_q;
    assign uop_valid   = vld_q;
    assign busy        = (state_q == S_SEQ);
    assign dbg_state_o = state_q;

endmodule
